// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Time-multiplexes a 4-digit 7-segment display between a mouse
//            data source and a message source. A prescaler divides each digit
//            slot into a blanked part and a lit part. The displayed word and
//            dot mask are only latched at frame start, so one frame always
//            shows a single source and a single value.
// Ports    : clk, reset_n       - clock / asynchronous active-low reset
//            mouse_valid/value  - strobe + 16-bit mouse word (shadowed)
//            msg_req/value/dots - level request + message word + dot mask
//            msg_ack            - one-cycle acceptance pulse
//            msg_active         - message owns the display
//            digit_sel/bin/dot/en - per-digit outputs to the segment decoder
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
    parameter int TICK_MAX     = 99999,
    parameter int BLANK_CYCLES = 1000,
    parameter int HOLD_FRAMES  = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mouse_valid,
    input  logic [15:0] mouse_value,
    input  logic        msg_req,
    input  logic [15:0] msg_value,
    input  logic [3:0]  msg_dots,
    output logic        msg_ack,
    output logic        msg_active,
    output logic [1:0]  digit_sel,
    output logic [3:0]  digit_bin,
    output logic        digit_dot,
    output logic        digit_en
);

    localparam int C_PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int C_HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [C_HW-1:0] C_HOLD      = C_HW'(HOLD_FRAMES);
    localparam logic [3:0]      C_MOUSE_DOT = 4'b0100;

    typedef enum logic [0:0] {
        ST_MOUSE = 1'b0,
        ST_MSG   = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [C_PW-1:0]   r_presc;
    logic [1:0]        r_digit_sel;
    logic [15:0]       r_shadow;
    logic [15:0]       r_msg_word;
    logic [3:0]        r_msg_dots;
    logic [15:0]       r_word;
    logic [3:0]        r_dots;
    logic [C_HW-1:0]   r_hold, w_hold_nxt;
    logic              r_fresh, w_fresh_nxt;   // next frame start is the message's first frame
    logic              r_req_d;
    logic              r_ack;
    logic              r_active;

    logic              w_slot_end;
    logic              w_frame_start;
    logic              w_req_rise;
    logic              w_latch_msg;
    logic [15:0]       w_mouse_cur;

    assign w_slot_end    = (r_presc == C_PW'(TICK_MAX));
    assign w_frame_start = w_slot_end && (r_digit_sel == 2'd3);
    assign w_req_rise    = msg_req && !r_req_d;
    // A strobe on the frame-start edge itself still counts as "before" it.
    assign w_mouse_cur   = mouse_valid ? mouse_value : r_shadow;

    // Timing: prescaler and digit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc     <= '0;
            r_digit_sel <= 2'd0;
        end else if (w_slot_end) begin
            r_presc     <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_presc     <= r_presc + C_PW'(1);
        end
    end

    // Input capture: mouse shadow, message capture on request rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_msg_word <= '0;
            r_msg_dots <= '0;
            r_req_d    <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_req_d <= msg_req;
            r_ack   <= w_req_rise;
            if (mouse_valid) begin
                r_shadow <= mouse_value;
            end
            if (w_req_rise) begin
                r_msg_word <= msg_value;
                r_msg_dots <= msg_dots;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_MOUSE;
            r_hold  <= '0;
            r_fresh <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_fresh <= w_fresh_nxt;
        end
    end

    // FSM next state. The hold counter is not touched on the first message
    // frame; afterwards a frame start with one frame left hands back to mouse.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_fresh_nxt = r_fresh;
        w_latch_msg = 1'b0;
        case (r_state)
            ST_MOUSE: begin
                if (w_req_rise) begin
                    w_state_nxt = ST_MSG;
                    w_hold_nxt  = C_HOLD;
                    w_fresh_nxt = 1'b1;
                end
            end
            ST_MSG: begin
                if (w_frame_start) begin
                    w_latch_msg = 1'b1;
                    if (r_fresh) begin
                        w_fresh_nxt = 1'b0;
                    end else if (r_hold <= C_HW'(1)) begin
                        w_state_nxt = ST_MOUSE;
                        w_hold_nxt  = '0;
                        w_latch_msg = 1'b0;
                    end else begin
                        w_hold_nxt  = r_hold - C_HW'(1);
                    end
                end
                // A new request overrides an expiry on the same cycle.
                if (w_req_rise) begin
                    w_state_nxt = ST_MSG;
                    w_hold_nxt  = C_HOLD;
                    w_fresh_nxt = 1'b1;
                    w_latch_msg = w_frame_start;
                end
            end
            default: begin
                w_state_nxt = ST_MOUSE;
            end
        endcase
    end

    // Display word latch, only at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word   <= '0;
            r_dots   <= '0;
            r_active <= 1'b0;
        end else if (w_frame_start) begin
            r_active <= w_latch_msg;
            if (w_latch_msg) begin
                r_word <= r_msg_word;
                r_dots <= r_msg_dots;
            end else begin
                r_word <= w_mouse_cur;
                r_dots <= C_MOUSE_DOT;
            end
        end
    end

    always_comb begin
        digit_bin = r_word[3:0];
        case (r_digit_sel)
            2'd0:    digit_bin = r_word[3:0];
            2'd1:    digit_bin = r_word[7:4];
            2'd2:    digit_bin = r_word[11:8];
            default: digit_bin = r_word[15:12];
        endcase
    end

    assign digit_dot  = r_dots[r_digit_sel];
    assign digit_sel  = r_digit_sel;
    assign digit_en   = (r_presc >= C_PW'(BLANK_CYCLES));
    assign msg_ack    = r_ack;
    assign msg_active = r_active;

endmodule
`default_nettype wire

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 Parameter TICK_MAX, default 99999: clock cycles per digit slot, minus one.
REQ-002 Parameter BLANK_CYCLES, default 1000: blanked cycles at the start of each slot; 0 < BLANK_CYCLES <= TICK_MAX.
REQ-003 Parameter HOLD_FRAMES, default 200: number of full 4-digit frames a message is shown.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 MOUSE_VALID  input  1  one-cycle strobe that marks MOUSE_VALUE as new.
REQ-007 MOUSE_VALUE  input  16  four nibbles of region/coordinate data from the mouse path.
REQ-008 MSG_REQ  input  1  level request to display a message.
REQ-009 MSG_VALUE  input  16  message nibbles; sampled on acceptance.
REQ-010 MSG_DOTS  input  4  per-digit decimal-point enables for the message; sampled on acceptance.
REQ-011 MSG_ACK  output  1  one-cycle acceptance pulse.
REQ-012 MSG_ACTIVE  output  1  high while the message source owns the display.
REQ-013 DIGIT_SEL  output  2  active digit index 0..3, for the 7-segment decoder.
REQ-014 DIGIT_BIN  output  4  nibble for the active digit.
REQ-015 DIGIT_DOT  output  1  decimal point for the active digit.
REQ-016 DIGIT_EN  output  1  high when the digit is lit; low during blanking.

Function
REQ-017 The prescaler SHALL count 0..TICK_MAX and wrap; the wrap cycle is the slot boundary.
REQ-018 DIGIT_SEL SHALL increment by one at each slot boundary and wrap from 3 to 0; the 3->0 transition is the frame start.
REQ-019 DIGIT_EN SHALL be 0 while prescaler < BLANK_CYCLES and 1 otherwise.
REQ-020 MOUSE_VALID=1 SHALL load MOUSE_VALUE into a mouse shadow register on the same edge; the last strobe before a frame start wins.
REQ-021 The display word and dot mask SHALL be latched only at frame start, so no frame ever mixes two sources or two values.
REQ-022 Latch source selection: in state MSG, the message word and MSG_DOTS are latched; in state MOUSE, the mouse shadow and the fixed dot mask 4'b0100 (digit 2 dot) are latched.
REQ-023 DIGIT_BIN SHALL equal latched word bits [4*DIGIT_SEL+3 : 4*DIGIT_SEL], and DIGIT_DOT SHALL equal latched dot mask bit DIGIT_SEL.
REQ-024 The FSM SHALL have two states, MOUSE and MSG.
REQ-025 MOUSE -> MSG: when MSG_REQ=1, the block captures MSG_VALUE/MSG_DOTS, pulses MSG_ACK for one cycle, and loads the hold counter with HOLD_FRAMES.
REQ-026 In MSG, the hold counter SHALL decrement at each frame start after the first frame latched from the message; at 0 the FSM returns to MOUSE on that frame start and the mouse word is latched.
REQ-027 MSG_REQ=1 while in MSG SHALL be accepted: it recaptures the message, pulses MSG_ACK, and reloads the hold counter; the new value appears at the next frame start.
REQ-028 MSG_ACK SHALL pulse at most once per request; the requester must drop MSG_REQ for at least one cycle before another acceptance (rising-edge detect on MSG_REQ).
REQ-029 MSG_ACTIVE SHALL be 1 from the frame start that first latches the message until the frame start that latches the mouse word again.
REQ-030 A MSG_REQ rise and a hold-counter expiry on the same cycle: the request wins, the FSM stays in MSG, and the counter is reloaded.
REQ-031 A MOUSE_VALID during MSG SHALL update the shadow register without affecting the display.

Reset
REQ-032 While RESET_N=0, the block SHALL hold prescaler=0, DIGIT_SEL=0, DIGIT_EN=0, DIGIT_BIN=0, DIGIT_DOT=0, MSG_ACK=0, MSG_ACTIVE=0, state=MOUSE, shadow/latched/message registers=0, hold counter=0.
REQ-033 Reset asserted mid-message SHALL abandon the message with no MSG_ACK; after release, the first frame starts at prescaler 0, digit 0.

Verification (TICK_MAX=9, BLANK_CYCLES=2, HOLD_FRAMES=2)
REQ-034 Release reset with no inputs -> DIGIT_SEL steps 0,1,2,3,0 every 10 cycles; DIGIT_EN low for 2 cycles of each slot; DIGIT_BIN=0.
REQ-035 MOUSE_VALID with 16'h1234 mid-frame -> the display remains 0 until the next frame start, then shows digits 4,3,2,1 with DIGIT_DOT=1 only on digit 2.
REQ-036 MSG_REQ rise with 16'hABCD, dots 4'b1001 -> MSG_ACK for one cycle; from the next frame, D,C,B,A with dots on digits 0 and 3 for exactly 2 frames; MSG_ACTIVE high for those 2 frames only, then the mouse word returns.
REQ-037 A second MSG_REQ rise (16'h5555) during frame 2 of the message -> ACK; 5555 shown from the next frame for 2 more frames; no frame mixes values.
REQ-038 RESET_N pulsed low during the message -> all outputs zero immediately; after release, mouse source, MSG_ACTIVE=0, no ACK.
REQ-039 Held MSG_REQ=1 for 50 cycles -> exactly one MSG_ACK.
